// File: rtl/fifo_buffer.sv
// Synchronous FIFO of 2^ADDR_BITS words. It has a registered read port, so read latency is exactly one cycle.
// There is no backpressure: writes into a full FIFO and reads from an empty FIFO are dropped and raise sticky error flags.
module fifo_buffer #(
    parameter int WIDTH            = 16,
    parameter int ADDR_BITS        = 4,
    parameter int ALMOST_FULL_LVL  = (1 << ADDR_BITS) - 2,
    parameter int ALMOST_EMPTY_LVL = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 write_enable,
    input  logic [WIDTH-1:0]     write_data,
    input  logic                 read_enable,
    output logic [WIDTH-1:0]     read_data,
    output logic                 read_valid,
    output logic [ADDR_BITS:0]   count,
    output logic                 empty,
    output logic                 full,
    output logic                 almost_empty,
    output logic                 almost_full,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] PTR_ONE   = {{(ADDR_BITS-1){1'b0}}, 1'b1};
    localparam logic [ADDR_BITS:0]   CNT_ONE   = {{ADDR_BITS{1'b0}}, 1'b1};
    localparam logic [ADDR_BITS:0]   CNT_DEPTH = {1'b1, {ADDR_BITS{1'b0}}};

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS-1:0] rd_ptr;
    logic                 rd_acc;
    logic                 wr_acc;

    assign empty        = (count == '0);
    assign full         = (count == CNT_DEPTH);
    assign almost_full  = (32'(count) >= ALMOST_FULL_LVL);
    assign almost_empty = (32'(count) <= ALMOST_EMPTY_LVL);

    // A full FIFO still accepts a write when a read frees a slot in the same cycle.
    // A write never feeds a same-cycle read (there is no bypass).
    assign rd_acc = read_enable & ~empty;
    assign wr_acc = write_enable & (~full | rd_acc);

    // Storage has no reset, and clear does not touch it.
    always_ff @(posedge clk) begin
        if (wr_acc && !clear) begin
            mem[wr_ptr] <= write_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            read_valid <= 1'b0;
            read_data  <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            read_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            read_valid <= rd_acc;
            if (rd_acc) begin
                read_data <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + PTR_ONE;
            end
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (write_enable && full && !rd_acc) begin
                overflow <= 1'b1;
            end
            if (read_enable && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_buffer.sv
// Testbench for fifo_buffer. A queue model of the FIFO predicts every output on every cycle.
// A vector table and hand-written sequences cover wrap, full/empty corners, clear and async reset.
module tb_fifo_buffer;

    localparam int W = 16;
    localparam int AB = 4;
    localparam int D = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          clear;
    logic          write_enable;
    logic [W-1:0]  write_data;
    logic          read_enable;
    logic [W-1:0]  read_data;
    logic          read_valid;
    logic [AB:0]   count;
    logic          empty, full, almost_empty, almost_full, overflow, underflow;

    always #5 clk = ~clk;

    fifo_buffer #(.WIDTH(W), .ADDR_BITS(AB)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (clear),
        .write_enable (write_enable),
        .write_data   (write_data),
        .read_enable  (read_enable),
        .read_data    (read_data),
        .read_valid   (read_valid),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    int checks = 0;
    int failures = 0;

    logic [W-1:0] mdl[$];
    logic [W-1:0] exp_q[$];
    bit           m_rv, m_ovf, m_unf;
    logic [W-1:0] m_rd;

    typedef struct {
        bit           we;
        logic [W-1:0] wd;
        bit           re;
        bit           clr;
        int           e_count;
        bit           e_rv;
        logic [W-1:0] e_rd;
        bit           e_unf;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [W-1:0] e;
        chk("read_valid", 32'(read_valid), 32'(m_rv));
        if (m_rv) begin
            if (exp_q.size() == 0) begin
                chk("scoreboard_nonempty", 32'(0), 32'(1));
            end else begin
                e = exp_q.pop_front();
                m_rd = e;
            end
        end
        chk("read_data", 32'(read_data), 32'(m_rd));
        chk("count", 32'(count), 32'(mdl.size()));
        chk("empty", 32'(empty), 32'(mdl.size() == 0));
        chk("full", 32'(full), 32'(mdl.size() == D));
        chk("almost_empty", 32'(almost_empty), 32'(mdl.size() <= 2));
        chk("almost_full", 32'(almost_full), 32'(mdl.size() >= D - 2));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
    endtask

    task automatic cycle(input bit we, input logic [W-1:0] wd, input bit re, input bit clr);
        bit me, mf, rd, wr;
        me = (mdl.size() == 0);
        mf = (mdl.size() == D);
        rd = re && !me;
        wr = we && (!mf || rd);
        write_enable = we;
        write_data   = wd;
        read_enable  = re;
        clear        = clr;
        @(posedge clk);
        #1;
        if (clr) begin
            mdl.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_rv  = 1'b0;
        end else begin
            if (we && mf && !rd) m_ovf = 1'b1;
            if (re && me) m_unf = 1'b1;
            m_rv = rd;
            if (rd) exp_q.push_back(mdl.pop_front());
            if (wr) mdl.push_back(wd);
        end
        write_enable = 1'b0;
        read_enable  = 1'b0;
        clear        = 1'b0;
        check_model();
    endtask

    task automatic check_reset_outputs();
        chk("rst_count", 32'(count), 32'(0));
        chk("rst_read_valid", 32'(read_valid), 32'(0));
        chk("rst_read_data", 32'(read_data), 32'(0));
        chk("rst_overflow", 32'(overflow), 32'(0));
        chk("rst_underflow", 32'(underflow), 32'(0));
        chk("rst_empty", 32'(empty), 32'(1));
        chk("rst_full", 32'(full), 32'(0));
        chk("rst_almost_empty", 32'(almost_empty), 32'(1));
        chk("rst_almost_full", 32'(almost_full), 32'(0));
    endtask

    vec_t vecs[7];

    initial begin
        reset_n      = 1'b0;
        clear        = 1'b0;
        write_enable = 1'b0;
        write_data   = '0;
        read_enable  = 1'b0;
        m_rv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0; m_rd = '0;

        // Expected fields are hand-derived, independent of the queue model.
        vecs[0] = '{1'b1, 16'h1234, 1'b1, 1'b0, 1, 1'b0, 16'h0000, 1'b1};
        vecs[1] = '{1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b1, 16'h1234, 1'b1};
        vecs[2] = '{1'b0, 16'h0000, 1'b0, 1'b1, 0, 1'b0, 16'h1234, 1'b0};
        vecs[3] = '{1'b1, 16'h00A1, 1'b0, 1'b0, 1, 1'b0, 16'h1234, 1'b0};
        vecs[4] = '{1'b1, 16'h00A2, 1'b1, 1'b0, 1, 1'b1, 16'h00A1, 1'b0};
        vecs[5] = '{1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b1, 16'h00A2, 1'b0};
        vecs[6] = '{1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0, 16'h00A2, 1'b1};

        #2;
        check_reset_outputs();
        #10;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_model();

        for (int i = 0; i < 7; i++) begin
            cycle(vecs[i].we, vecs[i].wd, vecs[i].re, vecs[i].clr);
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_count));
            chk($sformatf("vec%0d_read_valid", i), 32'(read_valid), 32'(vecs[i].e_rv));
            chk($sformatf("vec%0d_read_data", i), 32'(read_data), 32'(vecs[i].e_rd));
            chk($sformatf("vec%0d_underflow", i), 32'(underflow), 32'(vecs[i].e_unf));
        end

        // Fill to full, then overflow, then drain and underflow.
        cycle(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < D; i++) cycle(1'b1, 16'(i), 1'b0, 1'b0);
        chk("fill_full", 32'(full), 32'(1));
        cycle(1'b1, 16'h0010, 1'b0, 1'b0);
        chk("fill_overflow", 32'(overflow), 32'(1));
        chk("fill_count16", 32'(count), 32'(16));
        for (int i = 0; i < D; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            chk("drain_order", 32'(read_data), 32'(i));
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("drain_underflow", 32'(underflow), 32'(1));

        // Full with simultaneous read and write.
        cycle(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < D; i++) cycle(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 16'hAAAA, 1'b1, 1'b0);
        chk("rw_full_count", 32'(count), 32'(16));
        chk("rw_full_no_ovf", 32'(overflow), 32'(0));
        for (int i = 0; i < D + 4; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        chk("rw_full_last", 32'(read_data), 32'(16'hAAAA));

        // Steady state at count 8 across several pointer wraps.
        cycle(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b1, 16'h0200 + 16'(i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 16'h0300 + 16'(i), 1'b1, 1'b0);
            chk("wrap_count8", 32'(count), 32'(8));
        end
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        chk("wrap_last", 32'(read_data), 32'(16'h0327));

        // Clear takes priority over a concurrent write.
        for (int i = 0; i < D + 1; i++) cycle(1'b1, 16'h0400 + 16'(i), 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        chk("pre_clear_count5", 32'(count), 32'(5));
        chk("pre_clear_ovf", 32'(overflow), 32'(1));
        cycle(1'b1, 16'hBEEF, 1'b0, 1'b1);
        chk("clear_count", 32'(count), 32'(0));
        chk("clear_ovf", 32'(overflow), 32'(0));
        chk("clear_empty", 32'(empty), 32'(1));

        // Asynchronous reset in the middle of a burst, checked before any clock edge.
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'h0500 + 16'(i), 1'b0, 1'b0);
        cycle(1'b1, 16'h0503, 1'b1, 1'b0);
        write_enable = 1'b1;
        write_data   = 16'h0504;
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_outputs();
        mdl.delete();
        exp_q.delete();
        m_rv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0; m_rd = '0;
        write_enable = 1'b0;
        #1;
        reset_n = 1'b1;
        cycle(1'b1, 16'h5A5A, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("post_reset_data", 32'(read_data), 32'(16'h5A5A));
        cycle(1'b0, '0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_buffer.md
FIFO_BUFFER -- requirements
Module: fifo_buffer

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits (1..64).
REQ-002 Parameter ADDR_BITS, default 4, storage depth DEPTH = 2^ADDR_BITS entries (2..10).
REQ-003 Parameter ALMOST_FULL_LVL, default DEPTH-2, count at or above which almost_full asserts.
REQ-004 Parameter ALMOST_EMPTY_LVL, default 2, count at or below which almost_empty asserts.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 clear  input  1  synchronous flush, active-high.
REQ-008 write_enable  input  1  write request.
REQ-009 write_data  input  WIDTH  word to store.
REQ-010 read_enable  input  1  read request.
REQ-011 read_data  output  WIDTH  registered output word.
REQ-012 read_valid  output  1  read_data holds a word popped in the previous cycle.
REQ-013 count  output  ADDR_BITS+1  number of stored words, 0..DEPTH.
REQ-014 empty, full, almost_empty, almost_full  output  1 each  status flags.
REQ-015 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 Storage SHALL be an internal DEPTH x WIDTH array; all DEPTH entries usable (no sacrificed slot).
REQ-017 Write and read pointers SHALL be ADDR_BITS wide and wrap modulo DEPTH from DEPTH-1 to 0.
REQ-018 empty SHALL equal (count == 0); full SHALL equal (count == DEPTH); both combinational from registered count.
REQ-019 almost_full SHALL equal (count >= ALMOST_FULL_LVL); almost_empty SHALL equal (count <= ALMOST_EMPTY_LVL).
REQ-020 Read accepted (rd_acc) SHALL be read_enable & ~empty.
REQ-021 Write accepted (wr_acc) SHALL be write_enable & (~full | rd_acc).
REQ-022 On wr_acc, write_data SHALL be stored at write pointer and write pointer incremented at the same edge.
REQ-023 On rd_acc, word at read pointer SHALL be loaded into read_data and read pointer incremented at the same edge; read_valid SHALL be 1 in the following cycle.
REQ-024 When no read is accepted, read_data SHALL hold its last value and read_valid SHALL be 0.
REQ-025 Read latency SHALL be exactly one cycle from the rd_acc edge; a word written at edge N is readable (empty=0) from edge N onward, earliest read_data at edge N+1.
REQ-026 No write-to-read bypass: read_enable while empty SHALL be rejected even if a write is accepted the same cycle.
REQ-027 count SHALL update as +1 (wr_acc only), -1 (rd_acc only), unchanged (both or neither).
REQ-028 Simultaneous rd_acc and wr_acc when full SHALL keep count at DEPTH with both pointers advancing.
REQ-029 overflow SHALL set on write_enable & full & ~rd_acc; underflow SHALL set on read_enable & empty; both held until clear or reset.
REQ-030 Rejected requests SHALL alter no pointer, count, or storage entry.
REQ-031 clear SHALL, at the next edge, zero both pointers, count, read_valid, overflow, underflow, and take priority over any concurrent read or write.
REQ-032 read_data SHALL be unchanged by clear; storage contents SHALL not be initialised.

Reset
REQ-033 reset_n low SHALL immediately force pointers=0, count=0, read_valid=0, read_data=0, overflow=0, underflow=0, independent of clk.
REQ-034 After reset, empty=1, full=0, almost_empty=1, almost_full=0 (given default levels).
REQ-035 Reset asserted mid-operation SHALL discard all stored words; release takes effect on the first clk edge after reset_n rises.

Verification
REQ-036 Defaults, write 16 words 0x0000..0x000F -> full=1, count=16, almost_full from count 14; 17th write -> overflow=1, count=16.
REQ-037 From full, read 16 words -> read_data 0x0000..0x000F in order, one per cycle, read_valid=1 each next cycle; then empty=1; extra read -> underflow=1.
REQ-038 From full, assert read_enable and write_enable with 0xAAAA for 4 cycles -> count stays 16, no overflow, 0xAAAA words appear after the original 16 on drain.
REQ-039 Empty, write 0x1234 and read same cycle -> read rejected, count=1, underflow=1; next-cycle read -> read_data=0x1234.
REQ-040 Write 40 words while reading continuously at count 8 -> pointer wrap-around with no data loss or reordering, count constant 8.
REQ-041 Count=5 with overflow set, assert clear with write_enable -> next cycle count=0, overflow=0, empty=1; reset_n pulsed low mid-burst -> outputs per REQ-033 without clk edge.
